// File: rtl/regfile_pkg.sv
// Shared defaults and named register numbers for the multi-port MIPS register file.
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_T0   = 8;
  localparam int REG_T1   = 9;
  localparam int REG_T2   = 10;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, set beats clear on the same register.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      IA,
  input  logic                   IE,
  input  logic [ADDR_W-1:0]      WA1,
  input  logic                   WE1,
  input  logic [ADDR_W-1:0]      WA2,
  input  logic                   WE2,
  output logic [2**ADDR_W-1:0]   pending
);
  localparam int DEPTH = 2**ADDR_W;
  // Register 0 can never be pending when it is hardwired to zero.
  localparam logic [DEPTH-1:0] ZERO_MASK = (ZERO_REG != 0) ? DEPTH'(1) : '0;

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      set_vec[i] = IE && (IA == ADDR_W'(i));
      clr_vec[i] = (WE1 && (WA1 == ADDR_W'(i))) || (WE2 && (WA2 == ADDR_W'(i)));
    end
    nxt = (set_vec | (pending & ~clr_vec)) & ~ZERO_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= nxt;
    end
  end
endmodule

// File: rtl/register_file_mp.sv
// Two-read / two-write register file with optional write-to-read bypass and a pending scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic [ADDR_W-1:0] WA1,
  input  logic              WE1,
  input  logic [DATA_W-1:0] WD1,
  input  logic [ADDR_W-1:0] WA2,
  input  logic              WE2,
  input  logic [DATA_W-1:0] WD2,
  input  logic [ADDR_W-1:0] IA,
  input  logic              IE
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr1_ok;
  logic              wr2_ok;

  // Port 2 owns a shared destination; port 1 is dropped on a conflict.
  assign wr2_ok = WE2 && !((ZERO_REG != 0) && (WA2 == '0));
  assign wr1_ok = WE1 && !((ZERO_REG != 0) && (WA1 == '0)) && !(WE2 && (WA2 == WA1));

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .IA      (IA),
    .IE      (IE),
    .WA1     (WA1),
    .WE1     (WE1),
    .WA2     (WA2),
    .WE2     (WE2),
    .pending (pending)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr1_ok) begin
        mem[WA1] <= WD1;
      end
      if (wr2_ok) begin
        mem[WA2] <= WD2;
      end
    end
  end

  // Returns {busy, data}; a bypassed write also reports not-busy so status matches data.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W:0] r;
    if ((ZERO_REG != 0) && (ra == '0)) begin
      r = '0;
    end else if ((BYPASS != 0) && wr2_ok && (WA2 == ra)) begin
      r = {1'b0, WD2};
    end else if ((BYPASS != 0) && wr1_ok && (WA1 == ra)) begin
      r = {1'b0, WD1};
    end else begin
      r = {pending[ra], mem[ra]};
    end
    return r;
  endfunction

  always_comb begin
    {BUSY1, RD1} = read_port(RA1);
    {BUSY2, RD2} = read_port(RA2);
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Randomized plus directed bench for register_file_mp, driving a bypass and a non-bypass instance in parallel.
module tb_register_file_mp;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RA1, RA2, WA1, WA2, IA;
  logic        WE1, WE2, IE;
  logic [31:0] WD1, WD2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;

  logic [31:0] m_mem [32];
  logic        m_pend [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .RD1(rd1_b), .RD2(rd2_b),
    .BUSY1(busy1_b), .BUSY2(busy2_b), .WA1(WA1), .WE1(WE1), .WD1(WD1),
    .WA2(WA2), .WE2(WE2), .WD2(WD2), .IA(IA), .IE(IE));

  register_file_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .RA1(RA1), .RA2(RA2), .RD1(rd1_n), .RD2(rd2_n),
    .BUSY1(busy1_n), .BUSY2(busy2_n), .WA1(WA1), .WE1(WE1), .WD1(WD1),
    .WA2(WA2), .WE2(WE2), .WD2(WD2), .IA(IA), .IE(IE));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference read: latest write wins (port 2 over port 1), register 0 is always zero.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'd0;
    if (byp && WE2 && WA2 == ra) return WD2;
    if (byp && WE1 && WA1 == ra) return WD1;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 1'b0;
    if (byp && ((WE2 && WA2 == ra) || (WE1 && WA1 == ra))) return 1'b0;
    return m_pend[ra];
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'd0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (WE1) begin m_mem[WA1] = WD1; m_pend[WA1] = 1'b0; end
      if (WE2) begin m_mem[WA2] = WD2; m_pend[WA2] = 1'b0; end
      if (IE)  m_pend[IA] = 1'b1;
      m_mem[0]  = 32'd0;
      m_pend[0] = 1'b0;
    end
  endtask

  task automatic idle();
    rst = 1'b0; WE1 = 1'b0; WE2 = 1'b0; IE = 1'b0;
    WA1 = 5'd0; WA2 = 5'd0; IA = 5'd0; WD1 = 32'd0; WD2 = 32'd0;
  endtask

  task automatic tick();
    #1;
    if (!rst) begin
      check("rd1_byp",   rd1_b,          exp_rd(RA1, 1'b1));
      check("rd2_byp",   rd2_b,          exp_rd(RA2, 1'b1));
      check("busy1_byp", {31'd0, busy1_b}, {31'd0, exp_busy(RA1, 1'b1)});
      check("busy2_byp", {31'd0, busy2_b}, {31'd0, exp_busy(RA2, 1'b1)});
      check("rd1_nb",    rd1_n,          exp_rd(RA1, 1'b0));
      check("rd2_nb",    rd2_n,          exp_rd(RA2, 1'b0));
      check("busy1_nb",  {31'd0, busy1_n}, {31'd0, exp_busy(RA1, 1'b0)});
      check("busy2_nb",  {31'd0, busy2_n}, {31'd0, exp_busy(RA2, 1'b0)});
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    idle();
    RA1 = 5'd0; RA2 = 5'd0;
    @(negedge clk);

    // Reset with garbage writes/issues present; they must be discarded.
    rst = 1'b1; WE1 = 1'b1; WA1 = 5'd3; WD1 = 32'hDEAD; IE = 1'b1; IA = 5'd4;
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      RA1 = 5'(a); RA2 = 5'(31 - a);
      #1;
      check("rst_rd1", rd1_b, 32'd0);
      check("rst_busy2", {31'd0, busy2_n}, 32'd0);
      tick();
    end

    // Write and bypass to t0.
    WE1 = 1'b1; WA1 = 5'(REG_T0); WD1 = 32'd10; RA1 = 5'(REG_T0);
    #1;
    check("bypass_same", rd1_b, 32'd10);
    check("nobyp_same", rd1_n, 32'd0);
    tick();
    idle(); RA1 = 5'(REG_T0);
    #1;
    check("nobyp_next", rd1_n, 32'd10);
    tick();

    // Dual write conflict on t1: port 2 wins.
    WE1 = 1'b1; WA1 = 5'(REG_T1); WD1 = 32'd20;
    WE2 = 1'b1; WA2 = 5'(REG_T1); WD2 = 32'd99; RA1 = 5'(REG_T1);
    #1;
    check("conflict_byp", rd1_b, 32'd99);
    tick();
    idle(); RA1 = 5'(REG_T1);
    #1;
    check("conflict_store", rd1_n, 32'd99);
    tick();

    // Zero register ignores writes and issues.
    WE2 = 1'b1; WA2 = 5'(REG_ZERO); WD2 = 32'hFFFF_FFFF; IE = 1'b1; IA = 5'(REG_ZERO);
    RA1 = 5'(REG_ZERO);
    #1;
    check("zero_same", rd1_b, 32'd0);
    tick();
    idle(); RA1 = 5'(REG_ZERO);
    #1;
    check("zero_next", rd1_n, 32'd0);
    check("zero_busy", {31'd0, busy1_b}, 32'd0);
    tick();

    // Scoreboard on t2.
    IE = 1'b1; IA = 5'(REG_T2); RA2 = 5'(REG_T2);
    #1;
    check("issue_no_comb", {31'd0, busy2_b}, 32'd0);
    tick();
    idle(); RA2 = 5'(REG_T2);
    #1;
    check("issue_busy", {31'd0, busy2_b}, 32'd1);
    tick();
    WE2 = 1'b1; WA2 = 5'(REG_T2); WD2 = 32'd30; RA2 = 5'(REG_T2);
    #1;
    check("wb_busy_byp", {31'd0, busy2_b}, 32'd0);
    check("wb_rd_byp", rd2_b, 32'd30);
    check("wb_busy_nb", {31'd0, busy2_n}, 32'd1);
    tick();
    idle(); RA2 = 5'(REG_T2);
    #1;
    check("wb_busy_nb_next", {31'd0, busy2_n}, 32'd0);
    tick();
    IE = 1'b1; IA = 5'(REG_T2); WE1 = 1'b1; WA1 = 5'(REG_T2); WD1 = 32'd30; RA2 = 5'(REG_T2);
    tick();
    idle(); RA2 = 5'(REG_T2);
    #1;
    check("set_wins", {31'd0, busy2_n}, 32'd1);
    tick();

    // Reset mid-operation: t0..t2 = 10/20/30, t2 pending.
    WE1 = 1'b1; WA1 = 5'(REG_T1); WD1 = 32'd20;
    tick();
    idle();
    rst = 1'b1; WE1 = 1'b1; WA1 = 5'(REG_T0); WD1 = 32'd77;
    tick();
    idle(); RA1 = 5'(REG_T0); RA2 = 5'(REG_T2);
    #1;
    check("midrst_rd1", rd1_b, 32'd0);
    check("midrst_rd2", rd2_n, 32'd0);
    check("midrst_busy2", {31'd0, busy2_b}, 32'd0);
    tick();

    // Randomized traffic, addresses often folded into a small range to provoke conflicts.
    for (int c = 0; c < 2000; c++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 63) == 0);
      WE1 = $urandom_range(0, 1) == 1;
      WE2 = $urandom_range(0, 1) == 1;
      IE  = $urandom_range(0, 3) == 0;
      WA1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      WA2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      IA  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      RA1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      RA2 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      WD1 = 32'($urandom);
      WD2 = 32'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the MIPS datapath, replacing the single-write-port 32×32 register file. It provides two combinational read ports and two synchronous write ports (ALU writeback and load/multicycle writeback), with an optional same-cycle write-to-read bypass. Register 0 is hardwired to zero. A per-register pending scoreboard lets the issue stage stall on registers still awaiting a multicycle result.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = a read of a register being written this cycle returns the incoming data; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never pending

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- RA1  in  ADDR_W  read address, port 1
- RA2  in  ADDR_W  read address, port 2
- RD1  out  DATA_W  read data, port 1
- RD2  out  DATA_W  read data, port 2
- BUSY1  out  1  pending status of RA1
- BUSY2  out  1  pending status of RA2
- WA1, WE1, WD1  in  ADDR_W/1/DATA_W  write port 1 (ALU writeback)
- WA2, WE2, WD2  in  ADDR_W/1/DATA_W  write port 2 (load/multicycle writeback)
- IA  in  ADDR_W  issue address: destination of a newly issued multicycle op
- IE  in  1  issue enable: marks IA pending

## Operation
- **Storage and scoreboard.** Storage is 2**ADDR_W × DATA_W. The scoreboard holds one pending bit per register.
- **Writes.** A write takes effect on the rising edge when its WEn=1. If WE1 and WE2 target the same address, port 2 wins and port 1 is dropped.
- **Register 0 (ZERO_REG=1).**
  - Writes to address 0 are ignored.
  - RD returns 0 for address 0, including through the bypass path.
  - IE with IA=0 is ignored, and BUSY for address 0 is always 0.
- **Reads.** RDn = stored value of RAn. With BYPASS=1 the bypass path overrides the stored value:
  - if WE2 && WA2==RAn, RDn = WD2;
  - else if WE1 && WA1==RAn, RDn = WD1.
- **Scoreboard update each edge.**
  - Any accepted write (WE1 or WE2) clears the pending bit of its address.
  - IE sets pending[IA].
  - If a set and a clear hit the same address in one cycle, the set wins (a new producer supersedes the old one).
- **BUSY outputs.** BUSYn = pending[RAn]. With BYPASS=1, BUSYn is forced to 0 when a write to RAn is accepted this cycle, so data and status stay consistent.
- **Reset.** On a rising edge with rst=1:
  - all registers go to 0 and all pending bits are cleared;
  - writes and issues presented in that cycle are discarded.
- **Outputs after reset.** After the reset edge, RD1=RD2=0 and BUSY1=BUSY2=0 for any address, provided no bypassed write is active.
- **No error output.** A write to a non-pending register is legal and leaves pending at 0.

## Timing
- Read latency is 0 cycles (combinational from RAn).
- Write latency is 1 edge. With BYPASS=0, the new value is visible on RD the cycle after WE.
- With BYPASS=1, the new value is visible in the same cycle as WE.
- Issue to BUSY: BUSY rises the cycle after IE (no combinational IE→BUSY path).
- Writeback to BUSY:
  - BYPASS=1: BUSY falls in the same cycle as the write;
  - BYPASS=0: BUSY falls on the next cycle.
- No internal FSM. All state is storage plus pending bits, each a single-cycle update.
- Reset mid-operation: pending state is lost. The pipeline must flush alongside rst.

## Structure
- Package `regfile_pkg` holds:
  - defaults: DATA_W_DEF=32, ADDR_W_DEF=5;
  - named register constants: REG_ZERO=0, REG_T0=8, REG_T1=9, REG_T2=10.
- Sub-module `reg_scoreboard` (parameter ADDR_W):
  - inputs: clk, rst, IA, IE, and the two clear ports (WAn with WEn);
  - outputs: the pending vector;
  - contains the set-wins rule and the zero-register masking.
- Top level contains storage, the port-2-priority write logic, and the bypass/BUSY muxes.

## Test plan
- **Reset.** Apply rst for 1 cycle, then sweep RA1/RA2 over 0..31. Required: RD=0 and BUSY=0 at every address.
- **Write and bypass.** WE1=1, WA1=8, WD1=10; in the same cycle RA1=8.
  - BYPASS=1: RD1=10 in that cycle.
  - BYPASS=0: RD1=0 in that cycle and 10 the next.
- **Dual-write conflict.** WE1 with WA1=9, WD1=20, plus WE2 with WA2=9, WD2=99, same cycle. Required: register 9 holds 99 afterwards. Also check the bypass in that cycle returns 99.
- **Zero register.** WE2 with WA2=0, WD2=0xFFFFFFFF, plus IE with IA=0. Required, with RA1=0: RD1=0 in the same cycle and the next, and BUSY1 stays 0.
- **Scoreboard.**
  - IE with IA=10. Required: BUSY2=1 (RA2=10) from the next cycle.
  - WE2 with WA2=10, WD2=30. Required: BUSY2=0 and RD2=30 in that cycle (BYPASS=1).
  - Simultaneous IE with IA=10 and WE1 with WA1=10. Required: pending stays 1.
- **Reset mid-operation.** Registers 8–10 hold 10/20/30 and register 10 is pending. Assert rst together with WE1 (WA1=8, WD1=77). Required next cycle: all registers 0 and BUSY=0; the write is discarded.
